// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register ids, status codes
// and the pipeline-control FSM state type.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [3:0] RRSP    = 4'h4;
   localparam logic [3:0] RNONE   = 4'hF;

   localparam logic [3:0] SAOK    = 4'h1;
   localparam logic [3:0] SHLT    = 4'h2;
   localparam logic [3:0] SADR    = 4'h3;
   localparam logic [3:0] SINS    = 4'h4;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_MWAIT = 2'd1,
      ST_HALT  = 2'd2,
      ST_ERR   = 2'd3
   } ctrl_state_t;

   function automatic logic is_memop(input logic [3:0] icode);
      return icode inside {IRMMOVQ, IMRMOVQ, IPUSHQ, IPOPQ, ICALL, IRET};
   endfunction

   function automatic logic is_exc(input logic [3:0] stat);
      return stat inside {SADR, SINS, SHLT};
   endfunction

endpackage

// File: rtl/y86_hazard_unit.sv
// Combinational hazard detection (load-use, mispredict, ret) and the
// stall/bubble controls used while the pipeline is running unfrozen.
module y86_hazard_unit
   import y86_pkg::*;
(
   input  logic [3:0] d_icode,
   input  logic [3:0] e_icode,
   input  logic [3:0] m_icode,
   input  logic [3:0] src_a,
   input  logic [3:0] src_b,
   input  logic [3:0] e_dst_m,
   input  logic       e_cnd,
   input  logic [3:0] m_stat,
   input  logic [3:0] w_stat,
   output logic       f_stall,
   output logic       d_stall,
   output logic       d_bubble,
   output logic       e_bubble,
   output logic       m_bubble,
   output logic       w_stall,
   output logic       set_cc,
   output logic       rf_we
);

   logic lu;
   logic mis;
   logic ret;

   assign lu  = (e_icode inside {IMRMOVQ, IPOPQ}) && (e_dst_m != RNONE)
              && ((e_dst_m == src_a) || (e_dst_m == src_b));
   assign mis = (e_icode == IJXX) && !e_cnd;
   assign ret = (d_icode == IRET) || (e_icode == IRET) || (m_icode == IRET);

   assign f_stall  = lu || ret;
   assign d_stall  = lu;
   // Load-use wins over ret: the stalled decode slot must not be squashed.
   assign d_bubble = mis || (ret && !lu);
   assign e_bubble = mis || lu;
   assign m_bubble = is_exc(m_stat) || is_exc(w_stat);
   assign w_stall  = (w_stat != SAOK);
   assign set_cc   = (e_icode == IOPQ) && !is_exc(m_stat) && !is_exc(w_stat);
   assign rf_we    = !w_stall;

endmodule

// File: rtl/y86_pipe_ctrl.sv
// Y86-64 pipeline control: run/halt/error FSM, data-memory wait sequencing
// with timeout, stall/bubble priority mux and performance counters.
module y86_pipe_ctrl
   import y86_pkg::*;
#(
   parameter int MEM_TMO = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [3:0]       D_icode_i,
   input  logic [3:0]       E_icode_i,
   input  logic [3:0]       M_icode_i,
   input  logic [3:0]       d_srcA_i,
   input  logic [3:0]       d_srcB_i,
   input  logic [3:0]       E_dstM_i,
   input  logic             e_Cnd_i,
   input  logic [3:0]       m_stat_i,
   input  logic [3:0]       W_stat_i,
   input  logic             dmem_ack_i,
   output logic             dmem_req_o,
   output logic             F_stall_o,
   output logic             D_stall_o,
   output logic             E_stall_o,
   output logic             M_stall_o,
   output logic             W_stall_o,
   output logic             D_bubble_o,
   output logic             E_bubble_o,
   output logic             M_bubble_o,
   output logic             set_cc_o,
   output logic             rf_we_o,
   output logic [3:0]       stat_o,
   output logic [CNT_W-1:0] cyc_cnt_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam int              WAIT_W   = (MEM_TMO > 2) ? $clog2(MEM_TMO) : 1;
   localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(MEM_TMO - 1);

   ctrl_state_t       state;
   logic [WAIT_W-1:0] wait_cnt;
   logic [3:0]        stat_reg;
   logic [CNT_W-1:0]  cyc_cnt;
   logic [CNT_W-1:0]  stall_cnt;
   logic              active;
   logic              freeze;

   logic h_f_stall, h_d_stall, h_d_bubble, h_e_bubble, h_m_bubble;
   logic h_w_stall, h_set_cc, h_rf_we;

   y86_hazard_unit u_hazard (
      .d_icode  (D_icode_i),
      .e_icode  (E_icode_i),
      .m_icode  (M_icode_i),
      .src_a    (d_srcA_i),
      .src_b    (d_srcB_i),
      .e_dst_m  (E_dstM_i),
      .e_cnd    (e_Cnd_i),
      .m_stat   (m_stat_i),
      .w_stat   (W_stat_i),
      .f_stall  (h_f_stall),
      .d_stall  (h_d_stall),
      .d_bubble (h_d_bubble),
      .e_bubble (h_e_bubble),
      .m_bubble (h_m_bubble),
      .w_stall  (h_w_stall),
      .set_cc   (h_set_cc),
      .rf_we    (h_rf_we)
   );

   assign active     = (state == ST_RUN) || (state == ST_MWAIT);
   // Gated by rst_n_i so a reset mid-access drops the request immediately.
   assign dmem_req_o = rst_n_i && active && is_memop(M_icode_i);
   assign freeze     = dmem_req_o && !dmem_ack_i;

   always_comb begin
      F_stall_o  = 1'b0;
      D_stall_o  = 1'b0;
      E_stall_o  = 1'b0;
      M_stall_o  = 1'b0;
      W_stall_o  = 1'b0;
      D_bubble_o = 1'b0;
      E_bubble_o = 1'b0;
      M_bubble_o = 1'b0;
      set_cc_o   = 1'b0;
      rf_we_o    = 1'b0;
      if (rst_n_i) begin
         if (!active || freeze) begin
            F_stall_o = 1'b1;
            D_stall_o = 1'b1;
            E_stall_o = 1'b1;
            M_stall_o = 1'b1;
            W_stall_o = 1'b1;
         end else begin
            F_stall_o  = h_f_stall;
            D_stall_o  = h_d_stall;
            W_stall_o  = h_w_stall;
            D_bubble_o = h_d_bubble;
            E_bubble_o = h_e_bubble;
            M_bubble_o = h_m_bubble;
            set_cc_o   = h_set_cc;
            rf_we_o    = h_rf_we;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= ST_RUN;
         wait_cnt  <= '0;
         stat_reg  <= SAOK;
         cyc_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         if (active) begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (F_stall_o) stall_cnt <= stall_cnt + CNT_W'(1);
         end
         case (state)
            ST_RUN, ST_MWAIT: begin
               if (W_stat_i == SHLT) begin
                  state    <= ST_HALT;
                  stat_reg <= SHLT;
               end else if ((W_stat_i == SADR) || (W_stat_i == SINS)) begin
                  state    <= ST_ERR;
                  stat_reg <= W_stat_i;
               end else if (state == ST_RUN) begin
                  if (freeze) begin
                     state    <= ST_MWAIT;
                     wait_cnt <= '0;
                  end
               end else if (dmem_ack_i) begin
                  state    <= ST_RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == TMO_LAST) begin
                  state    <= ST_ERR;
                  stat_reg <= SADR;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign stat_o      = stat_reg;
   assign cyc_cnt_o   = cyc_cnt;
   assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_y86_pipe_ctrl.sv
// Directed bench for y86_pipe_ctrl: a table of single-cycle hazard vectors
// followed by hand-written memory-wait, timeout, reset and halt sequences.
module tb_y86_pipe_ctrl;
   import y86_pkg::*;

   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [3:0]       D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM;
   logic             e_Cnd;
   logic [3:0]       m_stat, W_stat;
   logic             dmem_ack;
   logic             dmem_req, F_stall, D_stall, E_stall, M_stall, W_stall;
   logic             D_bubble, E_bubble, M_bubble, set_cc, rf_we;
   logic [3:0]       stat;
   logic [CNT_W-1:0] cyc_cnt, stall_cnt;

   y86_pipe_ctrl #(.MEM_TMO(4), .CNT_W(CNT_W)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .D_icode_i   (D_icode),
      .E_icode_i   (E_icode),
      .M_icode_i   (M_icode),
      .d_srcA_i    (d_srcA),
      .d_srcB_i    (d_srcB),
      .E_dstM_i    (E_dstM),
      .e_Cnd_i     (e_Cnd),
      .m_stat_i    (m_stat),
      .W_stat_i    (W_stat),
      .dmem_ack_i  (dmem_ack),
      .dmem_req_o  (dmem_req),
      .F_stall_o   (F_stall),
      .D_stall_o   (D_stall),
      .E_stall_o   (E_stall),
      .M_stall_o   (M_stall),
      .W_stall_o   (W_stall),
      .D_bubble_o  (D_bubble),
      .E_bubble_o  (E_bubble),
      .M_bubble_o  (M_bubble),
      .set_cc_o    (set_cc),
      .rf_we_o     (rf_we),
      .stat_o      (stat),
      .cyc_cnt_o   (cyc_cnt),
      .stall_cnt_o (stall_cnt)
   );

   always #5 clk = ~clk;

   // Control bits: {req, Fs, Ds, Es, Ms, Ws, Db, Eb, Mb, cc, we}
   typedef struct {
      string      name;
      logic [3:0] d_i, e_i, m_i, sa, sb, dm;
      logic       cnd;
      logic [3:0] ms, ws;
      logic       ack;
      logic [10:0] exp;
   } vec_t;

   localparam logic [10:0] C_IDLE   = 11'b0_00000_000_01;
   localparam logic [10:0] C_FROZEN = 11'b1_11111_000_00;
   localparam logic [10:0] C_HELD   = 11'b0_11111_000_00;
   localparam logic [10:0] C_ZERO   = 11'b0_00000_000_00;
   localparam logic [10:0] C_WEXC   = 11'b0_00001_001_00;

   vec_t vq[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   n_stall_exp;

   function automatic logic [10:0] ctrl_bits();
      return {dmem_req, F_stall, D_stall, E_stall, M_stall, W_stall,
              D_bubble, E_bubble, M_bubble, set_cc, rf_we};
   endfunction

   task automatic add(input string nm, input logic [3:0] di, ei, mi, sa, sb, dm,
                      input logic cnd, input logic [3:0] ms, ws, input logic ack,
                      input logic [10:0] exp);
      vec_t v;
      v.name = nm; v.d_i = di; v.e_i = ei; v.m_i = mi; v.sa = sa; v.sb = sb;
      v.dm = dm; v.cnd = cnd; v.ms = ms; v.ws = ws; v.ack = ack; v.exp = exp;
      vq.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      D_icode = v.d_i; E_icode = v.e_i; M_icode = v.m_i;
      d_srcA = v.sa; d_srcB = v.sb; E_dstM = v.dm; e_Cnd = v.cnd;
      m_stat = v.ms; W_stat = v.ws; dmem_ack = v.ack;
   endtask

   task automatic drive_idle();
      D_icode = INOP; E_icode = INOP; M_icode = INOP;
      d_srcA = RNONE; d_srcB = RNONE; E_dstM = RNONE; e_Cnd = 1'b1;
      m_stat = SAOK; W_stat = SAOK; dmem_ack = 1'b0;
   endtask

   task automatic chk_ctrl(input string nm, input logic [10:0] exp);
      logic [10:0] act;
      act = ctrl_bits();
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: ctrl got %b expected %b", nm, act, exp);
      end else
         $display("ok   %s: ctrl %b", nm, act);
   endtask

   task automatic chk_val(input string nm, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end else
         $display("ok   %s: %0d", nm, act);
   endtask

   // One clock of stimulus: drive just after the rising edge, check at the falling edge.
   task automatic cyc(input string nm, input logic [10:0] exp);
      @(posedge clk); #1;
      @(negedge clk);
      chk_ctrl(nm, exp);
   endtask

   task automatic set_mem(input logic [3:0] mi, input logic ack, input logic lu_on);
      drive_idle();
      M_icode = mi; dmem_ack = ack;
      if (lu_on) begin E_icode = IMRMOVQ; E_dstM = 4'd3; d_srcA = 4'd3; end
   endtask

   initial begin
      //   name         D      E        M        sA     sB     dM     c  mst   wst   ack exp
      add("idle",      INOP,  INOP,    INOP,    RNONE, RNONE, RNONE, 1, SAOK, SAOK, 0, C_IDLE);
      add("lu_srcA",   INOP,  IMRMOVQ, INOP,    4'd3,  RNONE, 4'd3,  1, SAOK, SAOK, 0, 11'b0_11000_010_01);
      add("lu_srcB",   INOP,  IPOPQ,   INOP,    RNONE, 4'd5,  4'd5,  1, SAOK, SAOK, 0, 11'b0_11000_010_01);
      add("no_lu_fF",  INOP,  IMRMOVQ, INOP,    RNONE, RNONE, RNONE, 1, SAOK, SAOK, 0, C_IDLE);
      add("no_lu_reg", INOP,  IMRMOVQ, INOP,    4'd1,  4'd2,  4'd3,  1, SAOK, SAOK, 0, C_IDLE);
      add("mispred",   INOP,  IJXX,    INOP,    RNONE, RNONE, RNONE, 0, SAOK, SAOK, 0, 11'b0_00000_110_01);
      add("jxx_taken", INOP,  IJXX,    INOP,    RNONE, RNONE, RNONE, 1, SAOK, SAOK, 0, C_IDLE);
      add("ret_D",     IRET,  INOP,    INOP,    RNONE, RNONE, RNONE, 1, SAOK, SAOK, 0, 11'b0_10000_100_01);
      add("ret_E",     INOP,  IRET,    INOP,    RNONE, RNONE, RNONE, 1, SAOK, SAOK, 0, 11'b0_10000_100_01);
      add("ret_M",     INOP,  INOP,    IRET,    RNONE, RNONE, RNONE, 1, SAOK, SAOK, 1, 11'b1_10000_100_01);
      add("lu_and_ret",IRET,  IMRMOVQ, INOP,    4'd3,  RNONE, 4'd3,  1, SAOK, SAOK, 0, 11'b0_11000_010_01);
      add("mis_and_ret",IRET, IJXX,    INOP,    RNONE, RNONE, RNONE, 0, SAOK, SAOK, 0, 11'b0_10000_110_01);
      add("opq_cc",    INOP,  IOPQ,    INOP,    RNONE, RNONE, RNONE, 1, SAOK, SAOK, 0, 11'b0_00000_000_11);
      add("opq_madr",  INOP,  IOPQ,    INOP,    RNONE, RNONE, RNONE, 1, SADR, SAOK, 0, 11'b0_00000_001_01);
      add("opq_mhlt",  INOP,  IOPQ,    INOP,    RNONE, RNONE, RNONE, 1, SHLT, SAOK, 0, 11'b0_00000_001_01);
      add("m_sins",    INOP,  INOP,    INOP,    RNONE, RNONE, RNONE, 1, SINS, SAOK, 0, 11'b0_00000_001_01);
      add("zero_wait", INOP,  INOP,    IMRMOVQ, RNONE, RNONE, RNONE, 1, SAOK, SAOK, 1, 11'b1_00000_000_01);
      add("push_zw",   INOP,  INOP,    IPUSHQ,  RNONE, RNONE, RNONE, 1, SAOK, SAOK, 1, 11'b1_00000_000_01);

      // Reset: controls forced low even with hazard and memop inputs present.
      rst_n = 1'b0;
      drive_idle();
      repeat (2) @(posedge clk);
      #1 set_mem(IMRMOVQ, 1'b0, 1'b1);
      #1;
      chk_ctrl("reset_ctrl", C_ZERO);
      chk_val("reset_stat", CNT_W'(stat), CNT_W'(SAOK));
      chk_val("reset_cyc", cyc_cnt, 0);
      chk_val("reset_stall", stall_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive_idle();

      n_stall_exp = 0;
      foreach (vq[i]) begin
         @(posedge clk); #1;
         drive(vq[i]);
         @(negedge clk);
         chk_ctrl(vq[i].name, vq[i].exp);
         if (vq[i].exp[9]) n_stall_exp++;
      end

      // Memory wait of three cycles with a concurrent load-use that must be deferred.
      @(posedge clk); #1;
      chk_val("tbl_cyc", cyc_cnt, CNT_W'(vq.size() + 1));
      chk_val("tbl_stall", stall_cnt, CNT_W'(n_stall_exp));
      set_mem(IMRMOVQ, 1'b0, 1'b1);
      @(negedge clk); chk_ctrl("mwait_1", C_FROZEN);
      cyc("mwait_2", C_FROZEN);
      cyc("mwait_3", C_FROZEN);
      @(posedge clk); #1 set_mem(IMRMOVQ, 1'b1, 1'b1);
      @(negedge clk); chk_ctrl("mwait_ack_lu", 11'b1_11000_010_01);
      @(posedge clk); #1 drive_idle();
      @(negedge clk); chk_ctrl("mwait_after", C_IDLE);
      chk_val("mwait_cyc", cyc_cnt, CNT_W'(vq.size() + 5));
      chk_val("mwait_stall", stall_cnt, CNT_W'(n_stall_exp + 4));

      // Timeout with MEM_TMO=4: one RUN cycle plus four MWAIT cycles, then ERR.
      @(posedge clk); #1 set_mem(IMRMOVQ, 1'b0, 1'b0);
      @(negedge clk); chk_ctrl("tmo_run", C_FROZEN);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk_ctrl($sformatf("tmo_wait_%0d", k), C_FROZEN);
      end
      chk_val("tmo_stat_ok", CNT_W'(stat), CNT_W'(SAOK));
      @(posedge clk); #1;
      @(negedge clk);
      chk_ctrl("tmo_err_ctrl", C_HELD);
      chk_val("tmo_err_stat", CNT_W'(stat), CNT_W'(SADR));
      chk_val("tmo_err_cyc", cyc_cnt, CNT_W'(vq.size() + 11));
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_val("tmo_cyc_frozen", cyc_cnt, CNT_W'(vq.size() + 11));
      chk_val("tmo_stall_frozen", stall_cnt, CNT_W'(n_stall_exp + 9));
      chk_ctrl("tmo_err_held", C_HELD);

      // Reset out of ERR, then abort an access mid-MWAIT with reset.
      #2 rst_n = 1'b0;
      #1 chk_val("err_rst_stat", CNT_W'(stat), CNT_W'(SAOK));
      chk_val("err_rst_cyc", cyc_cnt, 0);
      @(negedge clk); rst_n = 1'b1;
      cyc("abort_run", C_FROZEN);
      cyc("abort_mwait", C_FROZEN);
      #2 rst_n = 1'b0;
      #1 chk_ctrl("abort_req_drop", C_ZERO);
      @(negedge clk); rst_n = 1'b1; drive_idle();
      cyc("abort_after", C_IDLE);

      // Halt, reset mid-halt, then an SINS error.
      @(posedge clk); #1 W_stat = SHLT;
      @(negedge clk); chk_ctrl("halt_wstat", C_WEXC);
      @(posedge clk); #1 W_stat = SAOK;
      @(negedge clk); chk_ctrl("halt_ctrl", C_HELD);
      chk_val("halt_stat", CNT_W'(stat), CNT_W'(SHLT));
      #2 rst_n = 1'b0;
      #1 chk_val("halt_rst_stat", CNT_W'(stat), CNT_W'(SAOK));
      chk_val("halt_rst_cyc", cyc_cnt, 0);
      chk_val("halt_rst_stall", stall_cnt, 0);
      @(negedge clk); rst_n = 1'b1;
      cyc("halt_rst_run", C_IDLE);
      @(posedge clk); #1 W_stat = SINS;
      @(negedge clk); chk_ctrl("sins_wstat", C_WEXC);
      @(posedge clk); #1 W_stat = SAOK;
      @(negedge clk); chk_ctrl("sins_ctrl", C_HELD);
      chk_val("sins_stat", CNT_W'(stat), CNT_W'(SINS));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
